// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant-state encodings
// and the arbitration winner function used in the IDLE state.
package wb_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  // Round robin hands a simultaneous request to the master not granted last.
  function automatic logic [1:0] pick_winner(input logic cyc0, input logic cyc1,
                                             input logic rr_mode, input logic last1);
    logic [1:0] win;
    if (cyc0 && cyc1) begin
      if (rr_mode && !last1) win = GNT1;
      else win = GNT0;
    end else if (cyc0) begin
      win = GNT0;
    end else if (cyc1) begin
      win = GNT1;
    end else begin
      win = IDLE;
    end
    return win;
  endfunction

endpackage

// File: rtl/wb_arbiter_2_if.sv
// Wishbone cycle handshake (cyc/stb out, ack/err/rty back) with the views of
// a master, a slave and a passive monitor.
interface wb_arbiter_2_if;
  logic cyc;
  logic stb;
  logic ack;
  logic err;
  logic rty;

  modport master  (output cyc, stb, input ack, err, rty);
  modport slave   (input cyc, stb, output ack, err, rty);
  modport monitor (input cyc, stb, ack, err, rty);
endinterface

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts unanswered strobe cycles and fires once the slave has
// been silent for TIMEOUT cycles. TIMEOUT=0 builds no counter at all.
module wb_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_arbiter_2_if.monitor    bus,
  input  logic               state_chg,
  output logic               fire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_s;
      assign unused_s = ^{clk, rst_n, bus.cyc, bus.stb, bus.ack, bus.err, bus.rty, state_chg};
      assign fire = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt_r;
      logic          active_s;
      logic          resp_s;

      assign active_s = bus.cyc & bus.stb;
      assign resp_s   = bus.ack | bus.err | bus.rty;
      // A response in the firing cycle wins, so resp_s masks the fire term.
      assign fire     = active_s & ~resp_s & (cnt_r == CW'(TIMEOUT - 1));

      // Stall counter, restarted by any response, idle strobe, grant change or fire.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_r <= '0;
        end else if (!active_s || resp_s || state_chg || fire) begin
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter_2.sv
// Two-master Wishbone arbiter with fixed-priority or round-robin grant, a
// combinational bus mux to one shared slave and a response watchdog.
module wb_arbiter_2
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SELECT_WIDTH    = DATA_WIDTH / 8,
  parameter int ARB_ROUND_ROBIN = 0,
  parameter int TIMEOUT         = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_we_i,
  input  logic                    wbm0_stb_i,
  input  logic                    wbm0_cyc_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  output logic                    wbm0_rty_o,
  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_we_i,
  input  logic                    wbm1_stb_i,
  input  logic                    wbm1_cyc_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  output logic                    wbm1_rty_o,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_we_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  localparam logic RR_MODE = (ARB_ROUND_ROBIN != 0);

  logic [1:0] state_r;
  logic [1:0] state_next_s;
  logic       last1_r;
  logic       fire_s;
  logic       gnt0_s;
  logic       gnt1_s;

  // Next grant: arbitrate from IDLE, otherwise hold until the owner drops cyc.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = pick_winner(wbm0_cyc_i, wbm1_cyc_i, RR_MODE, last1_r);
      GNT0:    if (wbm0_cyc_i) state_next_s = GNT0; else state_next_s = IDLE;
      GNT1:    if (wbm1_cyc_i) state_next_s = GNT1; else state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Grant register and most-recently-granted pointer (master 1 after reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      last1_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      if (state_next_s == GNT1) last1_r <= 1'b1;
      else if (state_next_s == GNT0) last1_r <= 1'b0;
      else last1_r <= last1_r;
    end
  end

  assign grant_o = state_r;
  assign gnt0_s  = (state_r == GNT0);
  assign gnt1_s  = (state_r == GNT1);

  // Shared slave bus follows the granted master; everything is zero when idle.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cyc_o = 1'b0;
    case (state_r)
      GNT0: begin
        wbs_adr_o = wbm0_adr_i;
        wbs_dat_o = wbm0_dat_i;
        wbs_sel_o = wbm0_sel_i;
        wbs_we_o  = wbm0_we_i;
        wbs_stb_o = wbm0_stb_i;
        wbs_cyc_o = wbm0_cyc_i;
      end
      GNT1: begin
        wbs_adr_o = wbm1_adr_i;
        wbs_dat_o = wbm1_dat_i;
        wbs_sel_o = wbm1_sel_i;
        wbs_we_o  = wbm1_we_i;
        wbs_stb_o = wbm1_stb_i;
        wbs_cyc_o = wbm1_cyc_i;
      end
      default: begin
        wbs_stb_o = 1'b0;
        wbs_cyc_o = 1'b0;
      end
    endcase
  end

  wb_arbiter_2_if sbus ();
  assign sbus.cyc = wbs_cyc_o;
  assign sbus.stb = wbs_stb_o;
  assign sbus.ack = wbs_ack_i;
  assign sbus.err = wbs_err_i;
  assign sbus.rty = wbs_rty_i;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (sbus),
    .state_chg (state_next_s != state_r),
    .fire      (fire_s)
  );

  assign timeout_o  = fire_s;
  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign wbm0_ack_o = gnt0_s & wbs_ack_i;
  assign wbm1_ack_o = gnt1_s & wbs_ack_i;
  assign wbm0_rty_o = gnt0_s & wbs_rty_i;
  assign wbm1_rty_o = gnt1_s & wbs_rty_i;
  assign wbm0_err_o = gnt0_s & (wbs_err_i | fire_s);
  assign wbm1_err_o = gnt1_s & (wbs_err_i | fire_s);

endmodule

// File: doc/wb_arbiter_2.md
WB_ARBITER_2 -- requirements
Module: wb_arbiter_2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (8, 16, 32 or 64).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 The block SHALL have parameter SELECT_WIDTH, default DATA_WIDTH/8, byte select width.
REQ-004 The block SHALL have parameter ARB_ROUND_ROBIN, default 0; 0 selects fixed priority (master 0 highest) and 1 selects round robin.
REQ-005 The block SHALL have parameter TIMEOUT, default 256; this is the number of cycles without a slave response before a bus error is forced, and 0 disables the watchdog.
REQ-006 The block SHALL have exactly one clock and an asynchronous, active-low reset; the ports SHALL be named clk and rst_n.
REQ-007 The block SHALL provide these ports (N = 0, 1):
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wbmN_adr_i / wbmN_dat_i / wbmN_sel_i  in  ADDR_WIDTH / DATA_WIDTH / SELECT_WIDTH  master N address, write data, byte select.
- wbmN_we_i / wbmN_stb_i / wbmN_cyc_i  in  1  master N write enable, strobe, cycle.
- wbmN_dat_o  out  DATA_WIDTH  read data to master N.
- wbmN_ack_o / wbmN_err_o / wbmN_rty_o  out  1  acknowledge, error, retry to master N.
- wbs_adr_o / wbs_dat_o / wbs_sel_o  out  ADDR_WIDTH / DATA_WIDTH / SELECT_WIDTH  shared slave address, write data, byte select.
- wbs_we_o / wbs_stb_o / wbs_cyc_o  out  1  shared slave write enable, strobe, cycle.
- wbs_dat_i  in  DATA_WIDTH  read data from slave.
- wbs_ack_i / wbs_err_i / wbs_rty_i  in  1  slave acknowledge, error, retry.
- grant_o  out  2  one-hot current grant; 2'b00 means idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Function
REQ-008 The grant register SHALL be a state machine with three states: IDLE, GNT0 and GNT1; grant_o SHALL reflect the state (00, 01, 10).
REQ-009 In IDLE, if any wbmN_cyc_i is high, the next state SHALL be GNT of the winner; otherwise the state SHALL stay IDLE. Arbitration latency is 1 cycle.
REQ-010 With fixed priority, master 0 SHALL win a simultaneous request.
REQ-011 With round robin, a simultaneous request SHALL go to the master not granted most recently; after reset, the most recently granted master SHALL be 1.
REQ-012 In GNTn, the grant SHALL be held while wbmN_cyc_i is high, regardless of the other master's requests; when wbmN_cyc_i falls, the next state SHALL be IDLE. This gives one idle cycle between grants.
REQ-013 The wbs_adr_o, wbs_dat_o, wbs_sel_o and wbs_we_o outputs SHALL combinationally follow the granted master; in IDLE they SHALL be zero.
REQ-014 wbs_cyc_o and wbs_stb_o SHALL equal the granted master's cyc_i and stb_i; in IDLE they SHALL be 0.
REQ-015 wbmN_dat_o SHALL equal wbs_dat_i for both masters.
REQ-016 wbmN_ack_o and wbmN_rty_o SHALL pass the slave's ack and rty only to the granted master; the ungranted master SHALL see 0.
REQ-017 The watchdog counter SHALL increment each cycle in which wbs_cyc_o & wbs_stb_o is high and ack, err and rty are all low; it SHALL clear on any response, on stb low, and on a state change.
REQ-018 When the counter equals TIMEOUT-1 and no response is present, timeout_o SHALL pulse for 1 cycle, wbmN_err_o of the granted master SHALL be asserted in that cycle, and the counter SHALL clear.
REQ-019 wbmN_err_o SHALL equal (wbs_err_i | watchdog fire) gated by grant.
REQ-020 If a slave response arrives in the same cycle as the watchdog would fire, the response SHALL win: no timeout_o and no forced err.
REQ-021 The counter width SHALL be clog2(TIMEOUT+1); when TIMEOUT=0, the counter logic SHALL be removed and timeout_o SHALL be held at 0.

Reset
REQ-022 Asserting rst_n low SHALL, asynchronously, force the state to IDLE, clear the counter, set the round-robin pointer to 1, and drive grant_o=0, timeout_o=0 and all slave strobes low.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer with no ack or err to either master; deassertion SHALL be synchronized externally.

Structure
REQ-024 The state encodings (IDLE, GNT0, GNT1) SHALL be defined as localparams in a shared package, wb_pkg.
REQ-025 The watchdog SHALL be implemented as a sub-module, wb_watchdog, instantiated once.

Verification
REQ-026 Priority mode: both cyc rise together -> grant_o=01 on the next edge; master 1 sees no stb until master 0 drops cyc and one idle cycle passes.
REQ-027 Round-robin mode: three back-to-back simultaneous requests -> grant_o sequence 01, 10, 01.
REQ-028 TIMEOUT=4: slave never responds -> wbm0_err_o and timeout_o are high exactly at the 4th strobe cycle.
REQ-029 TIMEOUT=4: slave ack arrives in the 4th cycle -> ack passes through, and timeout_o and err stay 0.
REQ-030 Master 1 holds cyc for a 5-beat burst while master 0 requests -> grant stays 10 for all 5 acks.
REQ-031 rst_n pulsed low mid-write -> wbs_cyc_o=0 immediately, and grant_o=00 until the next request.
